// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared definitions for the program-counter unit.
//   - npc_sel_e  : next-PC source select encodings
//   - err_code_e : halt cause encodings
//   - state_e    : controller state encoding
//   - RESET_PC_DEFAULT / IM_WORDS_DEFAULT : default reset PC and IM depth
package pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          IM_WORDS_DEFAULT = 4096;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_REG    = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_WINDOW   = 2'b10
  } err_code_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/pc_if.sv
// pc_if: bundle between the pipeline front end and the PC unit.
//   master (front end / testbench): drives en, npc_sel, br_cond, imm16,
//     imm26, rs_data; observes pc, pc_plus4, halt, err_code, instr_count.
//   slave (pc_unit): the reverse direction.
interface pc_if;
  import pc_unit_pkg::*;

  logic        en;
  npc_sel_e    npc_sel;
  logic        br_cond;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halt;
  err_code_e   err_code;
  logic [31:0] instr_count;

  modport master (
    output en, npc_sel, br_cond, imm16, imm26, rs_data,
    input  pc, pc_plus4, halt, err_code, instr_count
  );

  modport slave (
    input  en, npc_sel, br_cond, imm16, imm26, rs_data,
    output pc, pc_plus4, halt, err_code, instr_count
  );

endinterface

// File: rtl/pc_unit_npc.sv
// npc_calc: combinational next-PC candidate generator.
//   pc       in  32  current PC
//   npc_sel  in   2  source select (seq / branch / jump / register)
//   br_cond  in   1  branch taken condition
//   imm16    in  16  signed word offset for branches
//   imm26    in  26  jump index
//   rs_data  in  32  register target for jr
//   target   out 32  candidate next PC (unchecked)
module npc_calc
  import pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  npc_sel_e    npc_sel,
  input  logic        br_cond,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] target
);

  logic [31:0] seq_pc;
  logic [31:0] br_offset;

  assign seq_pc    = pc + 32'd4;
  // Word offset: sign-extend then scale to bytes.
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = seq_pc;
    case (npc_sel)
      NPC_SEQ:    target = seq_pc;
      NPC_BRANCH: target = br_cond ? (seq_pc + br_offset) : seq_pc;
      // Jump keeps the 256 MB region of the delay-slot address.
      NPC_JUMP:   target = {seq_pc[31:28], imm26, 2'b00};
      NPC_REG:    target = rs_data;
      default:    target = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with target legality checking and halt FSM.
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous active-low reset
//   bus          pc_if.slave
//     en, npc_sel, br_cond, imm16, imm26, rs_data : next-PC controls
//     pc, pc_plus4, halt, err_code, instr_count   : status outputs
// Parameters: RESET_PC (window base / reset PC), IM_WORDS (window depth).
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IM_WORDS = IM_WORDS_DEFAULT
)(
  input  logic clk,
  input  logic reset,
  pc_if.slave  bus
);

  // Window bounds in 33 bits so the upper bound cannot wrap.
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(IM_WORDS) << 2);

  state_e      state, next_state;
  logic [31:0] pc_q;
  logic [31:0] count_q;
  err_code_e   err_q;
  logic [31:0] target;
  err_code_e   chk_err;
  logic        advance;
  logic        commit;
  logic        trap;
  logic        halt;

  npc_calc u_npc (
    .pc      (pc_q),
    .npc_sel (bus.npc_sel),
    .br_cond (bus.br_cond),
    .imm16   (bus.imm16),
    .imm26   (bus.imm26),
    .rs_data (bus.rs_data),
    .target  (target)
  );

  // Misalignment outranks the window check.
  always_comb begin
    chk_err = ERR_NONE;
    if (target[1:0] != 2'b00)
      chk_err = ERR_MISALIGN;
    else if (({1'b0, target} < WIN_LO) || ({1'b0, target} >= WIN_HI))
      chk_err = ERR_WINDOW;
  end

  assign advance = (state == ST_RUN) && bus.en;
  assign commit  = advance && (chk_err == ERR_NONE);
  assign trap    = advance && (chk_err != ERR_NONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:  if (trap) next_state = ST_HALT;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    halt = 1'b0;
    if (state == ST_HALT) halt = 1'b1;
  end

  // PC, committed-advance counter and latched halt cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
      err_q   <= ERR_NONE;
    end else if (commit) begin
      pc_q    <= target;
      count_q <= count_q + 32'd1;
    end else if (trap) begin
      err_q   <= chk_err;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.halt        = halt;
  assign bus.err_code    = err_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit with a scoreboard
// queue of expected states, filled when a step is driven and drained when
// the post-edge state is sampled.
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        halt;
    logic [1:0]  err;
    logic [31:0] count;
  } exp_t;

  exp_t sb_q[$];

  pc_if bus ();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    cmp({e.tag, ".pc"},          bus.pc,                 e.pc);
    cmp({e.tag, ".pc_plus4"},    bus.pc_plus4,           e.pc + 32'd4);
    cmp({e.tag, ".halt"},        32'(bus.halt),          32'(e.halt));
    cmp({e.tag, ".err_code"},    32'(bus.err_code),      32'(e.err));
    cmp({e.tag, ".instr_count"}, bus.instr_count,        e.count);
  endtask

  task automatic expect_state(input string tag, input logic [31:0] p, input logic h,
                              input logic [1:0] er, input logic [31:0] c);
    exp_t e;
    e.tag = tag; e.pc = p; e.halt = h; e.err = er; e.count = c;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs, record the expected post-edge state, then
  // sample 1 time unit after the edge.
  task automatic apply_stimulus(input string tag, input logic e, input logic [1:0] sel,
                                input logic br, input logic [15:0] i16, input logic [25:0] i26,
                                input logic [31:0] rs, input logic [31:0] p, input logic h,
                                input logic [1:0] er, input logic [31:0] c);
    bus.en      = e;
    bus.npc_sel = npc_sel_e'(sel);
    bus.br_cond = br;
    bus.imm16   = i16;
    bus.imm26   = i26;
    bus.rs_data = rs;
    expect_state(tag, p, h, er, c);
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Assert reset between edges, check the reset state immediately, release.
  task automatic do_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    expect_state(tag, 32'h3000, 1'b0, 2'b00, 32'd0);
    check_output();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.npc_sel = NPC_SEQ;
    bus.br_cond = 1'b0;
    bus.imm16   = 16'h0;
    bus.imm26   = 26'h0;
    bus.rs_data = 32'h0;
    #12;
    expect_state("por", 32'h3000, 1'b0, 2'b00, 32'd0);
    check_output();
    reset = 1'b1;

    apply_stimulus("seq1", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 2'b00, 1);
    apply_stimulus("seq2", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 2'b00, 2);
    apply_stimulus("seq3", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h300C, 0, 2'b00, 3);
    apply_stimulus("br_back1", 1, 2'b01, 1, 16'hFFFE, 26'h0, 32'h0, 32'h3008, 0, 2'b00, 4);
    apply_stimulus("br_back2", 1, 2'b01, 1, 16'hFFFE, 26'h0, 32'h0, 32'h3004, 0, 2'b00, 5);
    apply_stimulus("seq4", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 2'b00, 6);
    apply_stimulus("br_not_taken", 1, 2'b01, 0, 16'hFFFE, 26'h0, 32'h0, 32'h300C, 0, 2'b00, 7);
    apply_stimulus("stall_jr_bad", 0, 2'b11, 0, 16'h0, 26'h0, 32'h3002, 32'h300C, 0, 2'b00, 7);
    apply_stimulus("stall_br", 0, 2'b01, 1, 16'h0040, 26'h0, 32'h0, 32'h300C, 0, 2'b00, 7);

    do_reset("rst_stall");
    apply_stimulus("jal", 1, 2'b10, 0, 16'h0, 26'h0000C10, 32'h0, 32'h3040, 0, 2'b00, 1);
    apply_stimulus("jump_low", 1, 2'b10, 0, 16'h0, 26'h0, 32'h0, 32'h3040, 1, 2'b10, 1);

    do_reset("rst_from_halt1");
    apply_stimulus("jr_misalign", 1, 2'b11, 0, 16'h0, 26'h0, 32'h3002, 32'h3000, 1, 2'b01, 0);
    apply_stimulus("halt_en0", 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 1, 2'b01, 0);
    apply_stimulus("halt_seq", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3000, 1, 2'b01, 0);
    apply_stimulus("halt_jump", 1, 2'b10, 0, 16'h0, 26'h0000C10, 32'h0, 32'h3000, 1, 2'b01, 0);

    do_reset("rst_from_halt2");
    apply_stimulus("stall_jr_oow", 0, 2'b11, 0, 16'h0, 26'h0, 32'h7000, 32'h3000, 0, 2'b00, 0);
    apply_stimulus("jr_oow_hi", 1, 2'b11, 0, 16'h0, 26'h0, 32'h7000, 32'h3000, 1, 2'b10, 0);

    do_reset("rst3");
    apply_stimulus("jr_oow_lo", 1, 2'b11, 0, 16'h0, 26'h0, 32'h2FFC, 32'h3000, 1, 2'b10, 0);

    do_reset("rst4");
    apply_stimulus("jr_last_word", 1, 2'b11, 0, 16'h0, 26'h0, 32'h6FFC, 32'h6FFC, 0, 2'b00, 1);
    apply_stimulus("seq_past_end", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h6FFC, 1, 2'b10, 1);

    do_reset("rst5");
    apply_stimulus("seq5", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 2'b00, 1);
    apply_stimulus("seq6", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3008, 0, 2'b00, 2);
    apply_stimulus("jr_both_bad", 1, 2'b11, 0, 16'h0, 26'h0, 32'h7002, 32'h3008, 1, 2'b01, 2);

    do_reset("rst_mid_halt");
    apply_stimulus("after_reset", 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h3004, 0, 2'b00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset; base of the IM window.
REQ-002 Parameter IM_WORDS, default 4096: IM depth in words; legal PC window is [RESET_PC, RESET_PC+4*IM_WORDS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 en  input  1  advance enable; 0 = stall, PC and all state hold.
REQ-006 npc_sel  input  2  next-PC source: 00 sequential, 01 branch, 10 jump (j/jal), 11 register (jr).
REQ-007 br_cond  input  1  branch condition from ALU compare; used only when npc_sel=01.
REQ-008 imm16  input  16  branch offset field, in words, signed.
REQ-009 imm26  input  26  jump index field.
REQ-010 rs_data  input  32  register-target value for jr.
REQ-011 pc  output  32  current PC, drives IM address input.
REQ-012 pc_plus4  output  32  pc+4, combinational; link value for jal.
REQ-013 halt  output  1  1 while in HALT state.
REQ-014 err_code  output  2  halt cause: 00 none, 01 misaligned target, 10 out-of-window target.
REQ-015 instr_count  output  32  number of committed PC advances since reset.

Function
REQ-016 The block has two states, RUN and HALT; reset enters RUN.
REQ-017 Candidate target, all arithmetic mod 2^32:
- 00: pc+4.
- 01: pc+4+(sign_extend(imm16)<<2) if br_cond=1, else pc+4.
- 10: {pc_plus4[31:28], imm26, 2'b00}.
- 11: rs_data.
REQ-018 In RUN with en=1, the target is checked:
- target[1:0]!=0 -> err_code=01.
- else target outside the window -> err_code=10.
- misalignment takes priority over out-of-window.
REQ-019 In RUN with en=1 and a legal target: pc<=target on the next edge, and instr_count increments by 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-020 In RUN with en=1 and an illegal target: go to HALT on the next edge; pc holds its current value; instr_count does not increment; err_code latches the cause.
REQ-021 In RUN with en=0: no check is made; pc, instr_count, state and err_code hold, whatever npc_sel and the targets are.
REQ-022 HALT is absorbing: pc, instr_count and err_code hold regardless of en and npc_sel until reset; halt=1.
REQ-023 Latency: the new pc is visible one cycle after the enabling edge; pc_plus4 is combinational from pc with zero latency.
REQ-024 Sequential increment from the last window word (RESET_PC+4*IM_WORDS-4) is out-of-window and halts with err_code=10.

Reset
REQ-025 reset=0 asynchronously forces pc=RESET_PC, state=RUN, halt=0, err_code=00 and instr_count=0, including mid-stall and from HALT.
REQ-026 On the first rising edge after reset deasserts, normal RUN behaviour applies.

Structure
REQ-027 npc_sel encodings, err_code encodings, the state encoding and the RESET_PC default belong in a shared package, which the controller also uses.
REQ-028 One sub-module, npc_calc, computes the target combinationally from pc, npc_sel, br_cond, imm16, imm26 and rs_data.
REQ-029 pc_unit holds the PC register, the FSM, the legality check and the counter.

Verification
REQ-030 Reset, then 3 cycles at en=1, npc_sel=00 -> pc=3000, 3004, 3008, 300C; instr_count=3.
REQ-031 pc=3008, npc_sel=01, br_cond=1, imm16=16'hFFFE -> pc=3004 next cycle; with br_cond=0 -> pc=300C.
REQ-032 pc=3000, npc_sel=10, imm26=26'h0000C10 -> pc=3040; pc_plus4=3004 during the jal cycle.
REQ-033 npc_sel=11, rs_data=3002 -> halt=1, err_code=01, pc holds at 3000; later en toggles and sel changes -> no change.
REQ-034 npc_sel=11, rs_data=7000 with en=0 -> no halt; raise en -> halt=1, err_code=10.
REQ-035 Assert reset=0 mid-clock while in HALT -> immediately pc=3000, halt=0, err_code=00, instr_count=0.
